// File: rtl/frm_invert.sv
// Output-side dark-mode pixel stage: fades RGB colour inversion in and out across frames
// using a blend factor that only moves on the vertical-sync falling edge.
module frm_invert #(
  parameter int unsigned FW   = 4,
  parameter int unsigned STEP = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        vs_i,
  input  logic        hs_i,
  input  logic        de_i,
  input  logic [23:0] data_i,
  input  logic        rx_i,
  output logic        vs_o,
  output logic        hs_o,
  output logic        de_o,
  output logic [23:0] data_o,
  output logic [1:0]  state_o
);

  localparam int unsigned AW   = FW + 1;
  localparam int unsigned FULL = 32'(1) << FW;
  localparam int unsigned DW   = 10;
  localparam int unsigned PW   = DW + AW + 1;
  localparam int unsigned YW   = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FADE_IN  = 2'd1,
    S_ON       = 2'd2,
    S_FADE_OUT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   alpha_q, alpha_d;
  logic [AW-1:0]   alpha_up, alpha_dn;
  logic [31:0]     a_plus;
  logic            vs_q;
  logic            fe;

  logic            vs_s1_q, hs_s1_q, de_s1_q;
  logic [23:0]     c_q;
  logic [2:0][PW-1:0] p_q, p_d;
  logic [23:0]     y_d;

  logic [7:0]          c1;
  logic signed [DW-1:0] d1;
  logic signed [AW:0]  a_s;
  logic signed [PW-1:0] sh;
  logic signed [YW-1:0] y;

  // Frame edge: vs falling; the frame buffer freezes rx_i on this same event.
  assign fe      = vs_q & ~vs_i;
  assign state_o = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      alpha_q <= '0;
      vs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      alpha_q <= alpha_d;
      vs_q    <= vs_i;
    end
  end

  // Fade FSM: alpha moves by STEP per frame, saturating at 0 and FULL.
  always_comb begin
    state_d  = state_q;
    alpha_d  = alpha_q;
    a_plus   = 32'(alpha_q) + STEP;
    alpha_up = (a_plus >= FULL) ? AW'(FULL) : AW'(a_plus);
    alpha_dn = (32'(alpha_q) <= STEP) ? '0 : AW'(32'(alpha_q) - STEP);
    if (fe) begin
      case (state_q)
        S_IDLE: begin
          if (rx_i) begin
            state_d = S_FADE_IN;
            alpha_d = alpha_up;
          end
        end
        S_FADE_IN: begin
          if (rx_i) begin
            alpha_d = alpha_up;
            state_d = (32'(alpha_up) == FULL) ? S_ON : S_FADE_IN;
          end else begin
            alpha_d = alpha_dn;
            state_d = S_FADE_OUT;
          end
        end
        S_ON: begin
          if (!rx_i) begin
            alpha_d = alpha_dn;
            state_d = S_FADE_OUT;
          end
        end
        S_FADE_OUT: begin
          if (!rx_i) begin
            alpha_d = alpha_dn;
            state_d = (alpha_dn == '0) ? S_IDLE : S_FADE_OUT;
          end else begin
            alpha_d = alpha_up;
            state_d = S_FADE_IN;
          end
        end
        default: begin
          state_d = S_IDLE;
          alpha_d = '0;
        end
      endcase
    end
  end

  // Stage 1: p = (255 - 2c) * alpha per channel, using the alpha current at entry.
  always_comb begin
    p_d = '0;
    c1  = '0;
    d1  = '0;
    a_s = $signed({1'b0, alpha_q});
    for (int i = 0; i < 3; i++) begin
      c1     = data_i[8*i +: 8];
      d1     = $signed(10'd255 - {1'b0, c1, 1'b0});
      p_d[i] = PW'(PW'(d1) * PW'(a_s));
    end
  end

  // Stage 2: y = c + floor(p / 2**FW), clamped to a byte.
  always_comb begin
    y_d = '0;
    sh  = '0;
    y   = '0;
    for (int i = 0; i < 3; i++) begin
      sh = $signed(p_q[i]) >>> FW;
      y  = YW'($signed({1'b0, c_q[8*i +: 8]})) + YW'(sh);
      if (y[YW-1]) begin
        y_d[8*i +: 8] = 8'h00;
      end else if (|y[YW-2:8]) begin
        y_d[8*i +: 8] = 8'hFF;
      end else begin
        y_d[8*i +: 8] = y[7:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vs_s1_q <= 1'b0;
      hs_s1_q <= 1'b0;
      de_s1_q <= 1'b0;
      c_q     <= '0;
      p_q     <= '0;
      vs_o    <= 1'b0;
      hs_o    <= 1'b0;
      de_o    <= 1'b0;
      data_o  <= '0;
    end else begin
      vs_s1_q <= vs_i;
      hs_s1_q <= hs_i;
      de_s1_q <= de_i;
      c_q     <= data_i;
      p_q     <= p_d;
      vs_o    <= vs_s1_q;
      hs_o    <= hs_s1_q;
      de_o    <= de_s1_q;
      data_o  <= y_d;
    end
  end

endmodule
